muldiv_sequencer: RTL

//  Sequences the multi-cycle mult and div units for the main control FSM.

---
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_sequencer: launches mult/div, waits for completion, loads HI/LO.    |
// | Optional watchdog: MULDIV_WATCHDOG_EN.   Rev 1.0                           |
// +----------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_start,
  input  logic             op_sel,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mult_end,
  input  logic             div_end,
  output logic             mult_start,
  output logic             div_start,
  output logic             hi_ctrl,
  output logic             lo_ctrl,
  output logic             hi_load,
  output logic             lo_load,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_EXC   = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   end_sel;
  logic   mult_start_d, div_start_d;
  logic   hi_ctrl_d, lo_ctrl_d;
  logic   hi_load_d, lo_load_d;
  logic   busy_d, done_d, div_zero_d;

`ifdef MULDIV_WATCHDOG_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;
`else
  logic watchdog_cfg_unused;
  assign watchdog_cfg_unused = ^{CNT_W[0], TIMEOUT_CYCLES[0]};
`endif

  // Only the selected unit's completion counts; the other one is ignored.
  assign end_sel = sel_q ? div_end : mult_end;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    div_zero_d = 1'b0;
`ifdef MULDIV_WATCHDOG_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_start) begin
          sel_d = op_sel;
          if (op_sel && (divisor == '0)) begin
            state_d    = S_EXC;
            div_zero_d = 1'b1;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef MULDIV_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (end_sel) begin
          state_d = S_WRITE;
        end
`ifdef MULDIV_WATCHDOG_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d   = S_EXC;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    mult_start_d = (state_d == S_START) && !sel_d;
    div_start_d  = (state_d == S_START) && sel_d;
    hi_load_d    = (state_d == S_WRITE);
    lo_load_d    = (state_d == S_WRITE);
    hi_ctrl_d    = (state_d == S_WRITE) ? sel_d : hi_ctrl;
    lo_ctrl_d    = (state_d == S_WRITE) ? sel_d : lo_ctrl;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi_ctrl    <= 1'b0;
      lo_ctrl    <= 1'b0;
      hi_load    <= 1'b0;
      lo_load    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
`ifdef MULDIV_WATCHDOG_EN
      cnt_q      <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mult_start <= mult_start_d;
      div_start  <= div_start_d;
      hi_ctrl    <= hi_ctrl_d;
      lo_ctrl    <= lo_ctrl_d;
      hi_load    <= hi_load_d;
      lo_load    <= lo_load_d;
      busy       <= busy_d;
      done       <= done_d;
      div_zero   <= div_zero_d;
`ifdef MULDIV_WATCHDOG_EN
      cnt_q      <= cnt_d;
      timeout    <= timeout_d;
`endif
    end
  end

`ifndef MULDIV_WATCHDOG_EN
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire
